// File: rtl/rps_pkg.sv
// Shared definitions for the rock-paper-scissors round referee: choice codes,
// round results, FSM states and the judging / BCD helpers.
package rps_pkg;

  typedef enum logic [1:0] {
    ROCK    = 2'b00,
    SCISSOR = 2'b01,
    PAPER   = 2'b10,
    ILLEGAL = 2'b11
  } choice_t;

  typedef enum logic [1:0] {
    R_NONE,
    R_USER,
    R_COM,
    R_DRAW
  } result_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_JUDGE,
    S_REPORT,
    S_WAIT_REL
  } state_t;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    case (a)
      ROCK:    return (b == SCISSOR);
      SCISSOR: return (b == PAPER);
      PAPER:   return (b == ROCK);
      default: return 1'b0;
    endcase
  endfunction

  // R_NONE doubles as "round void" whenever either code is illegal.
  function automatic result_t judge(input logic [1:0] u, input logic [1:0] c);
    if (u == ILLEGAL || c == ILLEGAL) return R_NONE;
    if (u == c) return R_DRAW;
    return beats(u, c) ? R_USER : R_COM;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

endpackage

// File: rtl/rps_round_referee_if.sv
// Player-facing signal bundle of the round referee: key, choices, scores,
// result LEDs and the history port towards the markov learner.
interface rps_round_referee_if;

  logic       start_n;
  logic [1:0] user;
  logic [1:0] com;
  logic [1:0] com_loaded;
  logic [7:0] user_score;
  logic [7:0] com_score;
  logic       uwin;
  logic       cwin;
  logic       equ;
  logic       bad_choice;
  logic       hist_valid;
  logic [3:0] hist_comb;
  logic       game_over;

  modport master (
    output start_n, user, com,
    input  com_loaded, user_score, com_score, uwin, cwin, equ,
           bad_choice, hist_valid, hist_comb, game_over
  );

  modport slave (
    input  start_n, user, com,
    output com_loaded, user_score, com_score, uwin, cwin, equ,
           bad_choice, hist_valid, hist_comb, game_over
  );

endinterface

// File: rtl/key_debouncer.sv
// Active-low push-key conditioner: two-flop synchroniser, stable-level counters,
// a one-cycle press pulse and a level that is high once the key is re-armed.
module key_debouncer #(
  parameter int CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press,
  output logic o_released
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(CYCLES);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_lowCnt;
  logic [CW-1:0] r_highCnt;
  logic          r_armed;
  logic          r_press;
  logic          w_key;

  assign w_key = r_sync[1];

  // Armed starts low so a key held through reset must first be seen released.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_lowCnt  <= '0;
      r_highCnt <= '0;
      r_armed   <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (!w_key) begin
        r_highCnt <= '0;
        if (r_lowCnt != FULL) r_lowCnt <= r_lowCnt + CW'(1);
        if (r_armed && r_lowCnt == LAST) begin
          r_press <= 1'b1;
          r_armed <= 1'b0;
        end
      end else begin
        r_lowCnt <= '0;
        if (r_highCnt != FULL) r_highCnt <= r_highCnt + CW'(1);
        if (r_highCnt == LAST) r_armed <= 1'b1;
      end
    end
  end

  assign o_press    = r_press;
  assign o_released = r_armed;

endmodule

// File: rtl/rps_round_referee.sv
// Round referee: debounced play key, choice sampling, judging, BCD scores and
// history output. Define RPS_ROUND_LIMIT_EN to end the match at WIN_TARGET wins.
module rps_round_referee
  import rps_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int WIN_TARGET      = 5
) (
  input logic               clock,
  input logic               reset,
  rps_round_referee_if.slave bus
);

  state_t     r_state;
  state_t     w_nextState;
  logic       w_press;
  logic       w_armed;
  logic       w_histValid;
  logic       w_gameOver;
  result_t    w_result;
  logic [1:0] r_user;
  logic [1:0] r_comLoaded;
  logic [7:0] r_userScore;
  logic [7:0] r_comScore;
  logic       r_uwin;
  logic       r_cwin;
  logic       r_equ;
  logic       r_badChoice;

  key_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_startKey (
    .clock      (clock),
    .reset      (reset),
    .i_key_n    (bus.start_n),
    .o_press    (w_press),
    .o_released (w_armed)
  );

  assign w_result = judge(r_user, r_comLoaded);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_histValid = 1'b0;
    case (r_state)
      S_IDLE:     if (w_press && !w_gameOver) w_nextState = S_SAMPLE;
      S_SAMPLE:   w_nextState = S_JUDGE;
      S_JUDGE:    w_nextState = S_REPORT;
      S_REPORT: begin
        w_histValid = !r_badChoice;
        w_nextState = S_WAIT_REL;
      end
      S_WAIT_REL: if (w_armed) w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  // Flags are cleared at sampling so they always describe the latest judged round.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_user      <= 2'b00;
      r_comLoaded <= 2'b00;
      r_userScore <= 8'h00;
      r_comScore  <= 8'h00;
      r_uwin      <= 1'b0;
      r_cwin      <= 1'b0;
      r_equ       <= 1'b0;
      r_badChoice <= 1'b0;
    end else begin
      case (r_state)
        S_SAMPLE: begin
          r_user      <= bus.user;
          r_comLoaded <= bus.com;
          r_uwin      <= 1'b0;
          r_cwin      <= 1'b0;
          r_equ       <= 1'b0;
          r_badChoice <= 1'b0;
        end
        S_JUDGE: begin
          case (w_result)
            R_USER: begin
              r_uwin      <= 1'b1;
              r_userScore <= bcd_inc(r_userScore);
            end
            R_COM: begin
              r_cwin     <= 1'b1;
              r_comScore <= bcd_inc(r_comScore);
            end
            R_DRAW:  r_equ       <= 1'b1;
            default: r_badChoice <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef RPS_ROUND_LIMIT_EN
  localparam logic [6:0] TARGET = 7'(WIN_TARGET);

  logic       r_gameOver;
  logic [7:0] w_userNext;
  logic [7:0] w_comNext;

  assign w_userNext = (w_result == R_USER) ? bcd_inc(r_userScore) : r_userScore;
  assign w_comNext  = (w_result == R_COM)  ? bcd_inc(r_comScore)  : r_comScore;

  // Looks at the post-judge scores so game_over rises with the deciding score.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gameOver <= 1'b0;
    end else if (r_state == S_JUDGE &&
                 (bcd_to_bin(w_userNext) >= TARGET || bcd_to_bin(w_comNext) >= TARGET)) begin
      r_gameOver <= 1'b1;
    end
  end

  assign w_gameOver = r_gameOver;
`else
  logic w_unused_target;
  assign w_unused_target = (WIN_TARGET > 0);
  assign w_gameOver      = 1'b0;
`endif

  assign bus.com_loaded = r_comLoaded;
  assign bus.user_score = r_userScore;
  assign bus.com_score  = r_comScore;
  assign bus.uwin       = r_uwin;
  assign bus.cwin       = r_cwin;
  assign bus.equ        = r_equ;
  assign bus.bad_choice = r_badChoice;
  assign bus.hist_valid = w_histValid;
  assign bus.hist_comb  = {r_comLoaded, r_user};
  assign bus.game_over  = w_gameOver;

endmodule

// File: tb/tb_rps_round_referee.sv
// Self-checking bench for rps_round_referee against a score-count reference model;
// compile with RPS_ROUND_LIMIT_EN defined to exercise the match limit.
module tb_rps_round_referee;

  localparam int CYC = 4;
`ifdef RPS_ROUND_LIMIT_EN
  localparam int TARGET = 2;
`else
  localparam int TARGET = 5;
`endif

  logic clock = 1'b0;
  logic reset;

  rps_round_referee_if bus ();

  rps_round_referee #(.DEBOUNCE_CYCLES(CYC), .WIN_TARGET(TARGET)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int         nCompared   = 0;
  int         nMismatched = 0;
  int         mUser, mCom;
  logic       mUwin, mCwin, mEqu, mBad, mOver;
  logic [1:0] mComLoaded;
  int         histCount;
  logic [3:0] histComb;
  int         expHist;
  logic [3:0] expComb;

  function automatic logic [7:0] toBcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function logic [22:0] expVec();
    return {mUwin, mCwin, mEqu, mBad, toBcd(mUser), toBcd(mCom), mComLoaded, mOver};
  endfunction

  function logic [22:0] obsVec();
    return {bus.uwin, bus.cwin, bus.equ, bus.bad_choice, bus.user_score, bus.com_score,
            bus.com_loaded, bus.game_over};
  endfunction

  task modelReset();
    mUser = 0; mCom = 0;
    mUwin = 0; mCwin = 0; mEqu = 0; mBad = 0; mOver = 0;
    mComLoaded = 2'b00;
  endtask

  // Winner found arithmetically: a beats b when b sits one step after a, modulo 3.
  task modelRound(input logic [1:0] u, input logic [1:0] c);
    expHist = 0;
    expComb = 4'h0;
    if (mOver) return;
    mComLoaded = c;
    mUwin = 0; mCwin = 0; mEqu = 0; mBad = 0;
    if (u == 2'd3 || c == 2'd3) begin
      mBad = 1;
    end else begin
      expHist = 1;
      expComb = {c, u};
      if (u == c) mEqu = 1;
      else if (((int'(c) - int'(u) + 3) % 3) == 1) begin
        mUwin = 1;
        if (mUser < 99) mUser++;
      end else begin
        mCwin = 1;
        if (mCom < 99) mCom++;
      end
    end
`ifdef RPS_ROUND_LIMIT_EN
    if (mUser >= TARGET || mCom >= TARGET) mOver = 1;
`endif
  endtask

  task watchHist(input int cycles, input int scrambleAt);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (bus.hist_valid === 1'b1) begin
        histCount++;
        if (histCount == 1) histComb = bus.hist_comb;
      end
      if (i == scrambleAt) begin
        bus.user = 2'($urandom_range(0, 3));
        bus.com  = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task applyStimulus(input logic [1:0] u, input logic [1:0] c);
    bus.user    = u;
    bus.com     = c;
    bus.start_n = 1'b0;
    histCount   = 0;
    histComb    = 4'h0;
    watchHist(16, 12);
    bus.start_n = 1'b1;
    watchHist(14, 3);
    modelRound(u, c);
  endtask

  task applyReset();
    reset       = 1'b1;
    bus.start_n = 1'b1;
    bus.user    = 2'b00;
    bus.com     = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    modelReset();
    repeat (CYC + 6) @(negedge clock);
  endtask

  task test_reset();
    nCompared++;
    if (obsVec() !== expVec() || bus.hist_valid !== 1'b0 || bus.hist_comb !== 4'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_state act=%h/%b/%h exp=%h/0/0", obsVec(), bus.hist_valid,
               bus.hist_comb, expVec());
    end
  endtask

  task test_glitch();
    histCount   = 0;
    bus.start_n = 1'b0;
    repeat (3) @(negedge clock);
    bus.start_n = 1'b1;
    watchHist(20, -1);
    nCompared++;
    if (histCount !== 0 || obsVec() !== expVec()) begin
      nMismatched++;
      $display("[TB] FAIL glitch act=%0d/%h exp=0/%h", histCount, obsVec(), expVec());
    end
  endtask

  task test_user_win();
    applyStimulus(2'b00, 2'b01);
    nCompared++;
    if (obsVec() !== expVec()) begin
      nMismatched++;
      $display("[TB] FAIL user_win act=%h exp=%h", obsVec(), expVec());
    end
    nCompared++;
    if (histCount !== 1 || histComb !== 4'b0100) begin
      nMismatched++;
      $display("[TB] FAIL user_win_hist act=%0d/%b exp=1/0100", histCount, histComb);
    end
  endtask

  task test_draw_then_com();
    applyStimulus(2'b10, 2'b10);
    nCompared++;
    if (obsVec() !== expVec() || histCount !== expHist) begin
      nMismatched++;
      $display("[TB] FAIL draw act=%h/%0d exp=%h/%0d", obsVec(), histCount, expVec(), expHist);
    end
    applyStimulus(2'b01, 2'b00);
    nCompared++;
    if (obsVec() !== expVec() || histCount !== expHist) begin
      nMismatched++;
      $display("[TB] FAIL com_win act=%h/%0d exp=%h/%0d", obsVec(), histCount, expVec(), expHist);
    end
  endtask

  task test_illegal();
    applyStimulus(2'b11, 2'b00);
    nCompared++;
    if (obsVec() !== expVec() || histCount !== 0) begin
      nMismatched++;
      $display("[TB] FAIL illegal_user act=%h/%0d exp=%h/0", obsVec(), histCount, expVec());
    end
    applyStimulus(2'b10, 2'b11);
    nCompared++;
    if (obsVec() !== expVec() || histCount !== 0) begin
      nMismatched++;
      $display("[TB] FAIL illegal_com act=%h/%0d exp=%h/0", obsVec(), histCount, expVec());
    end
  endtask

  task test_random();
    for (int k = 0; k < 24; k++) begin
      logic [1:0] u, c;
      u = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      applyStimulus(u, c);
      nCompared++;
      if (obsVec() !== expVec() || histCount !== expHist ||
          (expHist == 1 && histComb !== expComb)) begin
        nMismatched++;
        $display("[TB] FAIL random_%0d u=%b c=%b act=%h/%0d/%b exp=%h/%0d/%b", k, u, c, obsVec(),
                 histCount, histComb, expVec(), expHist, expComb);
      end
    end
  endtask

  task test_reset_mid_round();
    applyStimulus(2'b10, 2'b00);
    bus.user    = 2'b00;
    bus.com     = 2'b01;
    bus.start_n = 1'b0;
    repeat (8) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    modelReset();
    nCompared++;
    if (obsVec() !== expVec() || bus.hist_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL mid_reset act=%h/%b exp=%h/0", obsVec(), bus.hist_valid, expVec());
    end
    @(negedge clock);
    reset     = 1'b0;
    histCount = 0;
    watchHist(20, -1);
    nCompared++;
    if (histCount !== 0 || obsVec() !== expVec()) begin
      nMismatched++;
      $display("[TB] FAIL held_key act=%0d/%h exp=0/%h", histCount, obsVec(), expVec());
    end
    bus.start_n = 1'b1;
    repeat (14) @(negedge clock);
    applyStimulus(2'b00, 2'b10);
    nCompared++;
    if (obsVec() !== expVec() || histCount !== 1) begin
      nMismatched++;
      $display("[TB] FAIL after_reset act=%h/%0d exp=%h/1", obsVec(), histCount, expVec());
    end
  endtask

`ifdef RPS_ROUND_LIMIT_EN
  task test_game_over();
    applyReset();
    applyStimulus(2'b01, 2'b10);
    nCompared++;
    if (obsVec() !== expVec()) begin
      nMismatched++;
      $display("[TB] FAIL first_win act=%h exp=%h", obsVec(), expVec());
    end
    applyStimulus(2'b10, 2'b00);
    nCompared++;
    if (obsVec() !== expVec() || bus.game_over !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL game_over act=%h exp=%h", obsVec(), expVec());
    end
    applyStimulus(2'b00, 2'b01);
    nCompared++;
    if (obsVec() !== expVec() || histCount !== 0) begin
      nMismatched++;
      $display("[TB] FAIL press_after_over act=%h/%0d exp=%h/0", obsVec(), histCount, expVec());
    end
  endtask
`else
  task test_bcd_saturation();
    applyReset();
    for (int k = 1; k <= 100; k++) begin
      applyStimulus(2'b00, 2'b01);
      if (k == 9 || k == 10 || k == 99 || k == 100) begin
        nCompared++;
        if (obsVec() !== expVec()) begin
          nMismatched++;
          $display("[TB] FAIL bcd_win_%0d act=%h exp=%h", k, obsVec(), expVec());
        end
      end
    end
  endtask
`endif

  initial begin
    applyReset();
    test_reset();
    test_glitch();
    test_user_win();
    test_draw_then_com();
    test_illegal();
    test_random();
    test_reset_mid_round();
`ifdef RPS_ROUND_LIMIT_EN
    test_game_over();
`else
    test_bcd_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
